// File: rtl/sec_alert_sequencer.sv
// Alert arbiter and emergency evacuation sequencer for the site security core.
// Optional stall-timeout on the alert channel: define ALERT_TIMEOUT_EN.
module sec_alert_sequencer #(
   parameter int unsigned EVAC_DLY    = 8,
   parameter int unsigned BACKUP_CYC  = 4,
   parameter int unsigned CLEAR_CYC   = 16,
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fire,
   input  logic       earth_quake,
   input  logic [3:0] sec_req,
   input  logic       fire_dept_ack,
   input  logic       alert_ready,
   output logic       alert_valid,
   output logic [2:0] alert_src,
   output logic [5:0] alert_pending,
   output logic       fire_alarm,
   output logic       fire_exit,
   output logic       door_unlock,
   output logic       server_backup_signal,
   output logic       fire_dept_alert,
   output logic       alert_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, ALARM = 2'd1, EVAC = 2'd2, HOLD = 2'd3} state_t;

   localparam int unsigned DLY_W = $clog2(EVAC_DLY) + 1;
   localparam int unsigned BK_W  = $clog2(BACKUP_CYC) + 1;
   localparam int unsigned CLR_W = $clog2(CLEAR_CYC) + 1;
   localparam logic [2:0]  NONE  = 3'd7;

   logic             fire_q;
   logic             quake_q;
   logic [3:0]       sec_q;
   logic [5:0]       rise;
   logic [5:0]       clr;
   logic [1:0]       rr_ptr;
   logic             accept;
   logic             emerg;
   logic [2:0]       winner;
   state_t           state;
   logic [DLY_W-1:0] dly_cnt;
   logic [BK_W-1:0]  bk_cnt;
   logic [CLR_W-1:0] quiet_cnt;

   // Fire beats quake; sections searched from the slot after the last served one.
   function automatic logic [2:0] pick(input logic [5:0] p, input logic [1:0] rr);
      logic [2:0] r;
      logic [1:0] idx;
      r = NONE;
      if (p[4]) begin
         r = 3'd4;
      end else if (p[5]) begin
         r = 3'd5;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            idx = rr + 2'(k);
            r   = (r == NONE && p[idx]) ? {1'b0, idx} : r;
         end
      end
      return r;
   endfunction

   assign rise   = {earth_quake & ~quake_q, fire & ~fire_q, sec_req & ~sec_q};
   assign accept = alert_valid & alert_ready;
   assign emerg  = fire | earth_quake;
   assign winner = pick(alert_pending, rr_ptr);

   // Pending-bit clear mask for the alert being accepted this cycle.
   always_comb begin
      clr = 6'd0;
      if (accept) begin
         clr = 6'd1 << alert_src;
      end else begin
         clr = 6'd0;
      end
   end

`ifdef ALERT_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC) + 1;
   logic [STALL_W-1:0] stall_cnt;
`else
   if (TIMEOUT_CYC == 0) begin : g_no_timeout_cfg
   end
   assign alert_timeout = 1'b0;
`endif

   // Edge capture, pending flags and the valid/ready alert channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         fire_q        <= 1'b0;
         quake_q       <= 1'b0;
         sec_q         <= 4'd0;
         alert_pending <= 6'd0;
         alert_valid   <= 1'b0;
         alert_src     <= 3'd0;
         rr_ptr        <= 2'd0;
`ifdef ALERT_TIMEOUT_EN
         stall_cnt     <= '0;
         alert_timeout <= 1'b0;
`endif
      end else begin
         fire_q        <= fire;
         quake_q       <= earth_quake;
         sec_q         <= sec_req;
         alert_pending <= (alert_pending & ~clr) | rise;
`ifdef ALERT_TIMEOUT_EN
         alert_timeout <= 1'b0;
`endif
         if (accept) begin
            alert_valid <= 1'b0;
`ifdef ALERT_TIMEOUT_EN
            stall_cnt   <= '0;
`endif
            if (!alert_src[2]) begin
               rr_ptr <= alert_src[1:0];
            end
         end else if (alert_valid) begin
`ifdef ALERT_TIMEOUT_EN
            if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
               // Drop the offer but keep the pending bit so the source is retried.
               alert_valid   <= 1'b0;
               alert_timeout <= 1'b1;
               stall_cnt     <= '0;
               if (!alert_src[2]) begin
                  rr_ptr <= alert_src[1:0];
               end
            end else begin
               stall_cnt <= stall_cnt + STALL_W'(1);
            end
`endif
         end else if (winner != NONE) begin
            alert_valid <= 1'b1;
            alert_src   <= winner;
         end
      end
   end

   // Emergency evacuation sequence with registered actuator outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         dly_cnt              <= '0;
         bk_cnt               <= '0;
         quiet_cnt            <= '0;
         fire_alarm           <= 1'b0;
         fire_exit            <= 1'b0;
         door_unlock          <= 1'b0;
         server_backup_signal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (emerg) begin
                  state      <= ALARM;
                  dly_cnt    <= DLY_W'(EVAC_DLY - 1);
                  fire_alarm <= 1'b1;
               end
            end
            ALARM: begin
               if (dly_cnt == DLY_W'(0)) begin
                  state                <= EVAC;
                  bk_cnt               <= BK_W'(BACKUP_CYC - 1);
                  fire_exit            <= 1'b1;
                  door_unlock          <= 1'b1;
                  server_backup_signal <= 1'b1;
               end else begin
                  dly_cnt <= dly_cnt - DLY_W'(1);
               end
            end
            EVAC: begin
               if (bk_cnt == BK_W'(0)) begin
                  state                <= HOLD;
                  quiet_cnt            <= '0;
                  server_backup_signal <= 1'b0;
               end else begin
                  bk_cnt <= bk_cnt - BK_W'(1);
               end
            end
            HOLD: begin
               if (emerg) begin
                  quiet_cnt <= '0;
               end else if (quiet_cnt == CLR_W'(CLEAR_CYC - 1)) begin
                  state       <= IDLE;
                  quiet_cnt   <= '0;
                  fire_alarm  <= 1'b0;
                  fire_exit   <= 1'b0;
                  door_unlock <= 1'b0;
               end else begin
                  quiet_cnt <= quiet_cnt + CLR_W'(1);
               end
            end
            default: begin
               state                <= IDLE;
               fire_alarm           <= 1'b0;
               fire_exit            <= 1'b0;
               door_unlock          <= 1'b0;
               server_backup_signal <= 1'b0;
            end
         endcase
      end
   end

   // Sticky fire department notification; a new fire edge outranks the ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         fire_dept_alert <= 1'b0;
      end else if (rise[4]) begin
         fire_dept_alert <= 1'b1;
      end else if (fire_dept_ack) begin
         fire_dept_alert <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sec_alert_sequencer.sv
// Directed self-checking bench for sec_alert_sequencer (default and ALERT_TIMEOUT_EN builds).
module tb_sec_alert_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fire = 1'b0;
   logic       earth_quake = 1'b0;
   logic [3:0] sec_req = 4'd0;
   logic       fire_dept_ack = 1'b0;
   logic       alert_ready = 1'b0;
   logic       alert_valid;
   logic [2:0] alert_src;
   logic [5:0] alert_pending;
   logic       fire_alarm;
   logic       fire_exit;
   logic       door_unlock;
   logic       server_backup_signal;
   logic       fire_dept_alert;
   logic       alert_timeout;

   int tests = 0;
   int failed = 0;

   sec_alert_sequencer dut (
      .clk                  (clk),
      .rst                  (rst),
      .fire                 (fire),
      .earth_quake          (earth_quake),
      .sec_req              (sec_req),
      .fire_dept_ack        (fire_dept_ack),
      .alert_ready          (alert_ready),
      .alert_valid          (alert_valid),
      .alert_src            (alert_src),
      .alert_pending        (alert_pending),
      .fire_alarm           (fire_alarm),
      .fire_exit            (fire_exit),
      .door_unlock          (door_unlock),
      .server_backup_signal (server_backup_signal),
      .fire_dept_alert      (fire_dept_alert),
      .alert_timeout        (alert_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_alarm"},  32'(fire_alarm), 32'd0);
      chk({tag, "_exit"},   32'(fire_exit), 32'd0);
      chk({tag, "_door"},   32'(door_unlock), 32'd0);
      chk({tag, "_backup"}, 32'(server_backup_signal), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk_idle_outputs("rst");
      chk("rst_valid",   32'(alert_valid), 32'd0);
      chk("rst_src",     32'(alert_src), 32'd0);
      chk("rst_pending", 32'(alert_pending), 32'd0);
      chk("rst_fda",     32'(fire_dept_alert), 32'd0);
      chk("rst_tmo",     32'(alert_timeout), 32'd0);
      rst = 1'b0;
      tick();

      // Round-robin over all four sections
      alert_ready = 1'b1;
      sec_req = 4'b1111;
      tick();
      chk("rr_pending_set", 32'(alert_pending), 32'h0f);
      chk("rr_no_valid_yet", 32'(alert_valid), 32'd0);
      tick();
      chk("rr_valid_0", 32'(alert_valid), 32'd1);
      chk("rr_src_0",   32'(alert_src), 32'd1);
      tick();
      chk("rr_bubble_0",  32'(alert_valid), 32'd0);
      chk("rr_pending_1", 32'(alert_pending), 32'h0d);
      tick();
      chk("rr_valid_1", 32'(alert_valid), 32'd1);
      chk("rr_src_1",   32'(alert_src), 32'd2);
      tick();
      chk("rr_bubble_1", 32'(alert_valid), 32'd0);
      tick();
      chk("rr_valid_2", 32'(alert_valid), 32'd1);
      chk("rr_src_2",   32'(alert_src), 32'd3);
      tick();
      chk("rr_bubble_2", 32'(alert_valid), 32'd0);
      tick();
      chk("rr_valid_3", 32'(alert_valid), 32'd1);
      chk("rr_src_3",   32'(alert_src), 32'd0);
      tick();
      chk("rr_bubble_3",  32'(alert_valid), 32'd0);
      chk("rr_pending_0", 32'(alert_pending), 32'd0);
      tick();
      chk("rr_quiet", 32'(alert_valid), 32'd0);

      // Priority: fire, then quake, then section 2; stall holds the source
      sec_req = 4'd0;
      tick();
      tick();
      alert_ready = 1'b0;
      fire = 1'b1;
      earth_quake = 1'b1;
      sec_req = 4'b0100;
      tick();
      chk("pri_pending", 32'(alert_pending), 32'h34);
      tick();
      chk("pri_valid_fire", 32'(alert_valid), 32'd1);
      chk("pri_src_fire",   32'(alert_src), 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("pri_stall_valid", 32'(alert_valid), 32'd1);
         chk("pri_stall_src",   32'(alert_src), 32'd4);
      end
      alert_ready = 1'b1;
      tick();
      chk("pri_bubble_fire",  32'(alert_valid), 32'd0);
      chk("pri_pending_fire", 32'(alert_pending), 32'h24);
      tick();
      chk("pri_valid_quake", 32'(alert_valid), 32'd1);
      chk("pri_src_quake",   32'(alert_src), 32'd5);
      tick();
      chk("pri_bubble_quake", 32'(alert_valid), 32'd0);
      tick();
      chk("pri_valid_sec", 32'(alert_valid), 32'd1);
      chk("pri_src_sec",   32'(alert_src), 32'd2);
      tick();
      chk("pri_bubble_sec", 32'(alert_valid), 32'd0);
      chk("pri_pending_0",  32'(alert_pending), 32'd0);
      fire = 1'b0;
      earth_quake = 1'b0;
      sec_req = 4'd0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Evacuation sequence: fire held 3 cycles, quake pulse inside HOLD
      fire = 1'b1;
      tick();
      chk("ev_alarm_on",  32'(fire_alarm), 32'd1);
      chk("ev_exit_shut", 32'(fire_exit), 32'd0);
      chk("ev_door_shut", 32'(door_unlock), 32'd0);
      chk("ev_fda_set",   32'(fire_dept_alert), 32'd1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("ev_alarm_exit_shut", 32'(fire_exit), 32'd0);
         if (i == 2) fire = 1'b0;
      end
      tick();
      chk("ev_evac_exit",   32'(fire_exit), 32'd1);
      chk("ev_evac_door",   32'(door_unlock), 32'd1);
      chk("ev_evac_backup", 32'(server_backup_signal), 32'd1);
      chk("ev_evac_alarm",  32'(fire_alarm), 32'd1);
      for (int i = 9; i <= 11; i++) begin
         tick();
         chk("ev_backup_high", 32'(server_backup_signal), 32'd1);
      end
      tick();
      chk("ev_hold_backup_off", 32'(server_backup_signal), 32'd0);
      chk("ev_hold_exit",       32'(fire_exit), 32'd1);
      for (int i = 13; i <= 17; i++) tick();
      earth_quake = 1'b1;
      tick();
      earth_quake = 1'b0;
      for (int i = 19; i <= 28; i++) tick();
      chk("ev_quiet_restarted", 32'(fire_alarm), 32'd1);
      for (int i = 29; i <= 33; i++) tick();
      chk("ev_hold_last", 32'(fire_exit), 32'd1);
      tick();
      chk_idle_outputs("ev_idle");
      chk("ev_fda_held", 32'(fire_dept_alert), 32'd1);

      // fire_dept_alert ack, then ack colliding with a new fire edge
      fire_dept_ack = 1'b1;
      tick();
      chk("fda_cleared", 32'(fire_dept_alert), 32'd0);
      fire_dept_ack = 1'b1;
      fire = 1'b1;
      tick();
      fire_dept_ack = 1'b0;
      chk("fda_set_wins", 32'(fire_dept_alert), 32'd1);
      chk("fda_alarm",    32'(fire_alarm), 32'd1);

      // Reset in the middle of EVAC
      for (int i = 0; i < 8; i++) tick();
      chk("mid_evac_exit", 32'(fire_exit), 32'd1);
      fire = 1'b0;
      rst = 1'b1;
      tick();
      chk_idle_outputs("mid_rst");
      chk("mid_rst_fda",     32'(fire_dept_alert), 32'd0);
      chk("mid_rst_pending", 32'(alert_pending), 32'd0);
      chk("mid_rst_valid",   32'(alert_valid), 32'd0);
      rst = 1'b0;
      tick();
      chk("mid_rst_idle", 32'(fire_alarm), 32'd0);

      // Stalled section 1 alert for 40 cycles
      alert_ready = 1'b0;
      sec_req = 4'b0010;
      tick();
      chk("to_pending", 32'(alert_pending), 32'h02);
      for (int i = 0; i < 40; i++) begin
         tick();
`ifdef ALERT_TIMEOUT_EN
         if (i == 32) begin
            chk("to_dropped", 32'(alert_valid), 32'd0);
            chk("to_pulse",   32'(alert_timeout), 32'd1);
            chk("to_pending_kept", 32'(alert_pending), 32'h02);
         end else begin
            chk("to_valid", 32'(alert_valid), 32'd1);
            chk("to_src",   32'(alert_src), 32'd1);
            chk("to_no_pulse", 32'(alert_timeout), 32'd0);
         end
`else
         chk("to_valid_held", 32'(alert_valid), 32'd1);
         chk("to_src_held",   32'(alert_src), 32'd1);
         chk("to_tied_low",   32'(alert_timeout), 32'd0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/sec_alert_sequencer.md
Name: sec_alert_sequencer

Overview:
- Clocked controller that sits between the combinational security core and the site alert/dispatch channel.
- Captures section breach events (sec0..sec3), fire and earth_quake events.
- Arbitrates these events onto one valid/ready alert channel: emergencies first, sections round-robin.
- Runs the emergency evacuation sequence that drives fire_alarm, fire_exit, door_unlock, server_backup_signal and fire_dept_alert.

Parameters:
- EVAC_DLY, 8: cycles in ALARM before exits open.
- BACKUP_CYC, 4: cycles server_backup_signal stays high in EVAC.
- CLEAR_CYC, 16: consecutive quiet cycles required to leave HOLD.
- TIMEOUT_CYC, 32: alert stall limit; used only with ALERT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, one clock domain.
- rst  in  1  reset; synchronous, active-high.
- fire  in  1  fire detector level.
- earth_quake  in  1  quake detector level.
- sec_req  in  4  section breach levels; bit i is sec_i.
- fire_dept_ack  in  1  fire department acknowledge; clears fire_dept_alert.
- alert_ready  in  1  dispatch channel ready.
- alert_valid  out  1  alert offered.
- alert_src  out  3  source of offered alert: 0-3 section, 4 fire, 5 quake.
- alert_pending  out  6  pending flags [5]=quake [4]=fire [3:0]=sections.
- fire_alarm  out  1  siren.
- fire_exit  out  1  fire exits open.
- door_unlock  out  1  main door unlocked.
- server_backup_signal  out  1  server backup trigger.
- fire_dept_alert  out  1  sticky fire department notification.
- alert_timeout  out  1  one-cycle stall-drop pulse; tied 0 without the macro.

Behaviour:
- Reset: synchronous, active-high. Every output is 0; FSM goes to IDLE; counters are 0; round-robin pointer is 0; input edge registers are 0. Reset mid-sequence aborts immediately.
- Capture:
  - A rising edge on any source (registered previous value vs current) sets its pending bit on the next edge.
  - Sources: sec_req[i], fire, earth_quake.
  - A level held high does not re-set the bit. A repeat edge while the bit is already pending merges.
  - If a set and an accept-clear hit the same bit in the same cycle, set wins.
- Arbitration:
  - Runs only when alert_valid=0.
  - Priority: fire > quake > sections round-robin, searching from rr_ptr+1 mod 4.
  - The winner is registered: alert_valid=1 and alert_src are driven the cycle after the pending bit is visible.
  - Minimum latency from source edge to alert_valid is 2 cycles.
- Handshake:
  - While alert_valid=1 and alert_ready=0, alert_src is held stable.
  - On an accept (valid and ready), the source's pending bit clears and alert_valid drops next cycle.
  - On an accept of a section source, rr_ptr is set to that section.
  - There is a mandatory 1-cycle bubble between alerts.
- Emergency FSM (emerg = fire | earth_quake, level):
  - IDLE: emerg=1 goes to ALARM and loads the counter with EVAC_DLY-1.
  - ALARM:
    - Outputs: fire_alarm=1, door_unlock=0.
    - The counter decrements each cycle; at 0 go to EVAC.
    - emerg dropping during ALARM does not abort.
  - EVAC:
    - Outputs: fire_alarm=1, fire_exit=1, door_unlock=1, server_backup_signal=1.
    - Stays for BACKUP_CYC cycles, then goes to HOLD.
  - HOLD:
    - Outputs: fire_alarm=1, fire_exit=1, door_unlock=1, server_backup_signal=0.
    - The quiet counter increments while emerg=0 and resets to 0 when emerg=1.
    - At CLEAR_CYC go to IDLE.
  - IDLE outputs are all 0.
- fire_dept_alert:
  - Sets on a fire rising edge and stays set until fire_dept_ack=1.
  - If set and ack occur in the same cycle, set wins.
  - earth_quake does not set it.
- Fire and quake edges in the same cycle: both pending bits set; fire is dispatched first and quake next, after the bubble.
- Counter widths are $clog2(param)+1. No wrap: counters saturate or reload per state.

Optional Feature:
- Macro: ALERT_TIMEOUT_EN.
- Defined:
  - A stall counter runs while alert_valid=1 and alert_ready=0.
  - After TIMEOUT_CYC stalled cycles, alert_valid drops and alert_timeout pulses for 1 cycle.
  - The pending bit stays set, so the source is retried.
  - For a section source, rr_ptr advances to that section so other sections are served first.
  - Fire/quake are retried immediately.
- Undefined: valid is held indefinitely; alert_timeout is constant 0; no stall counter is built.

Test Plan:
- Reset check: after rst all outputs read 0; assert rst mid-EVAC and the next cycle shows fire_alarm=0, fire_exit=0, door_unlock=0 with FSM in IDLE.
- Round-robin: sec_req=4'b1111 edge with alert_ready=1 gives alert_src sequence 1,2,3,0 (rr_ptr=0 after reset), alert_valid high 1 cycle each with 1-cycle gaps, then alert_pending=0.
- Priority: fire and earth_quake edges together with sec_req[2] give alert_src 4, then 5, then 2; alert_src stable while alert_ready held low for 5 cycles.
- Evacuation: fire=1 for 3 cycles then 0 gives fire_alarm at cycle+1, fire_exit/door_unlock after 8 ALARM cycles, server_backup_signal high exactly 4 cycles, IDLE after 16 quiet HOLD cycles; an earth_quake pulse inside HOLD restarts the quiet count.
- fire_dept_alert: set by a fire edge, held through the whole sequence, cleared by a one-cycle fire_dept_ack; ack plus a new fire edge in the same cycle keeps it 1.
- ALERT_TIMEOUT_EN: sec_req[1] with alert_ready=0 for 40 cycles gives alert_valid dropped at 32 stalled cycles, one alert_timeout pulse, and the alert re-offered; without the macro alert_valid stays high for all 40 cycles.
